// File: rtl/game_msg_arbiter.sv
// Round-robin arbiter sharing the inter-board message channel between game-control handlers.
// Buffers one 22-bit request per handler and reports done, overflow or timeout per handler.
module game_msg_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interboard_rst,
    input  logic [N_REQ-1:0]     req_en,
    input  logic [22*N_REQ-1:0]  req_payload,
    input  logic                 inter_ready,
    output logic                 ctrl_en,
    output logic                 ctrl_move_dir,
    output logic [4:0]           ctrl_block_x,
    output logic [2:0]           ctrl_block_y,
    output logic [3:0]           ctrl_msg_type,
    output logic [5:0]           ctrl_card,
    output logic [2:0]           ctrl_sel_len,
    output logic [N_REQ-1:0]     req_pending,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_overflow,
    output logic [N_REQ-1:0]     req_timeout
);
    localparam int MSG_W = 22;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_READY, DONE} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   grant, grant_nxt;
    logic [IDX_W-1:0]   pick, scan_idx;
    logic               found;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W:0]     cnt_inc;
    logic [MSG_W-1:0]   msg_buf [N_REQ];
    logic [MSG_W-1:0]   msg_q, msg_nxt;
    logic [N_REQ-1:0]   pending, grant_oh, finish, timeout_vec, accept, ovf_q;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // First pending handler at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr;
        scan_idx = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && pending[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
            scan_idx = wrap_inc(scan_idx);
        end
    end

    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant;
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        cnt_nxt     = cnt;
        msg_nxt     = msg_q;
        finish      = '0;
        timeout_vec = '0;
        case (state)
            IDLE: begin
                msg_nxt = '0;
                if (found) begin
                    grant_nxt = pick;
                    msg_nxt   = msg_buf[pick];
                    state_nxt = SEND;
                end
            end
            SEND: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_READY;
            end
            WAIT_READY: begin
                if (inter_ready) begin
                    state_nxt = DONE;
                end else if (cnt_inc == (CNT_W+1)'(TIMEOUT)) begin
                    timeout_vec = grant_oh;
                    finish      = grant_oh;
                    rr_ptr_nxt  = wrap_inc(grant);
                    cnt_nxt     = '0;
                    msg_nxt     = '0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt_inc[CNT_W-1:0];
                end
            end
            DONE: begin
                finish     = grant_oh;
                rr_ptr_nxt = wrap_inc(grant);
                msg_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on its own done/timeout cycle reloads the buffer instead of overflowing.
    assign accept = req_en & (~pending | finish);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            cnt     <= '0;
            msg_q   <= '0;
            pending <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N_REQ; i++) msg_buf[i] <= '0;
        end else if (interboard_rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant   <= '0;
            cnt     <= '0;
            msg_q   <= '0;
            pending <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < N_REQ; i++) msg_buf[i] <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            grant   <= grant_nxt;
            cnt     <= cnt_nxt;
            msg_q   <= msg_nxt;
            pending <= (pending & ~finish) | accept;
            ovf_q   <= req_en & pending & ~finish;
            for (int i = 0; i < N_REQ; i++) begin
                if (accept[i]) msg_buf[i] <= req_payload[i*MSG_W +: MSG_W];
            end
        end
    end

    assign ctrl_en      = (state == SEND);
    assign req_done     = (state == DONE) ? grant_oh : '0;
    assign req_timeout  = timeout_vec;
    assign req_pending  = pending;
    assign req_overflow = ovf_q;
    assign {ctrl_move_dir, ctrl_block_x, ctrl_block_y,
            ctrl_msg_type, ctrl_card, ctrl_sel_len} = msg_q;

endmodule

// File: doc/game_msg_arbiter.md
Name: game_msg_arbiter

Overview:
- Shares the single inter-board message channel between N_REQ game-control handlers (init draw, draw, place, turn end).
- Each handler posts one 22-bit message request. The arbiter buffers one request per handler and grants in round-robin order.
- It drives the ctrl_* bundle to the inter-board sender, waits for inter_ready, then returns a per-handler done pulse.
- Sits in GameControl between the handle_* blocks and the inter-board transmitter.

Parameters:
N_REQ, 4, number of requesting handlers (2..8).
TIMEOUT, 1023, maximum cycles spent in WAIT_READY before the grant is aborted (1..65535).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
interboard_rst  in  1  synchronous active-high reset from the peer board; same effect as rst
req_en  in  N_REQ  one-cycle request pulse per handler
req_payload  in  22*N_REQ  per handler, MSB..LSB: move_dir[1], block_x[5], block_y[3], msg_type[4], card[6], sel_len[3]; sampled only when that handler's req_en=1
inter_ready  in  1  sender finished the current message
ctrl_en  out  1  one-cycle send strobe
ctrl_move_dir  out  1  payload field
ctrl_block_x  out  5  payload field
ctrl_block_y  out  3  payload field
ctrl_msg_type  out  4  payload field
ctrl_card  out  6  payload field
ctrl_sel_len  out  3  payload field
req_pending  out  N_REQ  request buffered or in flight, per handler
req_done  out  N_REQ  one-cycle pulse: that handler's message was acknowledged
req_overflow  out  N_REQ  one-cycle pulse: req_en arrived while that handler was already pending; request dropped
req_timeout  out  N_REQ  one-cycle pulse: grant aborted after TIMEOUT cycles

Behaviour:
- Reset (rst low, asynchronous; or interboard_rst high at a clk edge):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All pending flags and buffers cleared.
  - All outputs 0.
  - Reset mid-transfer drops everything; no done or timeout pulse is issued.
- Capture, per handler i:
  - req_en[i]=1 with pending[i]=0: payload latched, pending[i]=1 at the next edge.
  - req_en[i]=1 with pending[i]=1: payload ignored, req_overflow[i]=1 for one cycle.
  - req_en[i] in the same cycle as req_done[i] or req_timeout[i]: accepted as a new request; pending stays 1 and the buffer is reloaded.
- State machine (IDLE, SEND, WAIT_READY, DONE):
  - IDLE: if any pending, grant = first pending index searching rr_ptr, rr_ptr+1, ... modulo N_REQ. Load the output field registers from that buffer. Next state SEND. Otherwise stay in IDLE.
  - SEND: ctrl_en=1 for exactly this cycle. Clear the timeout counter. Next state WAIT_READY.
  - WAIT_READY: inter_ready is sampled only here. inter_ready=1 -> DONE. Otherwise the counter increments; when the counter reaches TIMEOUT -> req_timeout[grant]=1, pending[grant] cleared, rr_ptr=(grant+1) mod N_REQ, next state IDLE.
  - DONE: req_done[grant]=1, pending[grant] cleared, rr_ptr=(grant+1) mod N_REQ, next state IDLE.
- Output fields:
  - Held stable from SEND through DONE inclusive.
  - Zero in IDLE, except that they are loaded at the IDLE->SEND edge.
  - Registered outputs; no combinational path from req_* to ctrl_*.
- Latency:
  - req_en at cycle T with the arbiter idle -> pending at T+1, ctrl_en at T+2.
  - inter_ready at cycle W -> req_done at W+1.
  - Minimum back-to-back spacing between ctrl_en strobes is 4 cycles.
- inter_ready asserted during IDLE, SEND or DONE is ignored.
- Round-robin guarantees each pending handler is served within N_REQ grants.

Test Plan:
- Single request: req_en[1] with payload x=5, y=2, msg_type=3, card=17, sel_len=1 at T; inter_ready at T+4 -> ctrl_en at T+2 only, fields held T+2..T+5, req_done[1] at T+5, ctrl_* back to 0 at T+6.
- Fairness: req_en=4'b1111 in one cycle, inter_ready one cycle after each WAIT_READY entry -> grant order 0,1,2,3; then req_en[0] and req_en[3] together -> order 0,3.
- Overflow: req_en[2] twice, 3 cycles apart, before inter_ready -> req_overflow[2] pulses once; the first payload is sent; exactly one req_done[2].
- Timeout: TIMEOUT=8, inter_ready held 0 -> req_timeout[0] exactly 8 cycles after SEND, then the next pending handler is granted.
- Reload on done: req_en[1] in the same cycle as req_done[1] -> second message sent with the new payload; no overflow pulse.
- Reset mid-operation: rst low during WAIT_READY with 3 pending -> all outputs 0 immediately (asynchronous); after release, no ctrl_en without new req_en. Repeat with interboard_rst high for 1 cycle -> same clearing at the next edge.
